key_beep_ctrl: RTL and testbench
================================

KEY_BEEP_CTRL -- requirements
Module: key_beep_ctrl

Interface
REQ-001 Parameter DEB_CYC, default 1_000_000, debounce stability window in clk cycles (20 ms at 50 MHz).
REQ-002 Parameter BEEP_CYC, default 5_000_000, length of one beep-on interval (100 ms).
REQ-003 Parameter GAP_CYC, default 5_000_000, silent interval between beeps of one pattern (100 ms).
REQ-004 Parameter LONG_CYC, default 50_000_000, hold time for a long press, counted from the debounced press (1 s).
REQ-005 clk  input  1  system clock, 50 MHz.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 key_n  input  1  raw push-button level, active-low, asynchronous to clk, may bounce.
REQ-008 req  input  1  single-cycle request from other logic to sound a pattern.
REQ-009 req_cnt  input  2  beep count for req, 1-3; value 0 ignores req.
REQ-010 en_buz  output  1  enable to the downstream tone generator; 1 = tone on.
REQ-011 key_press  output  1  one-cycle pulse on a debounced press.
REQ-012 key_long  output  1  one-cycle pulse when a press has been held for LONG_CYC.
REQ-013 busy  output  1  high while a beep pattern is in progress.

Function
REQ-014 key_n shall pass through a 2-flop synchronizer before any other use.
REQ-015 The debounced level shall take the synchronized value only after that value differs from the debounced level for DEB_CYC consecutive cycles; any return to the debounced value clears the counter.
REQ-016 A debounced 1->0 transition shall assert key_press for exactly one cycle; a debounced 0->1 transition produces no pulse.
REQ-017 A hold counter shall start at the press and assert key_long for one cycle when the key stays debounced-low for LONG_CYC cycles; key_long fires at most once per press; release clears the counter.
REQ-018 The pattern FSM shall have states IDLE, ON and GAP, a cycle counter, and a remaining-beeps register rem (2 bits).
REQ-019 Triggers: key_press loads 1 beep, key_long loads 2 beeps, req with req_cnt != 0 loads req_cnt beeps.
REQ-020 Same-cycle priority: key_long > key_press > req; lower-priority triggers in that cycle are dropped.
REQ-021 A trigger in any state, IDLE included, shall restart the pattern: next state ON, counter cleared, rem = loaded count; the pattern in progress is abandoned.
REQ-022 ON: en_buz = 1 for exactly BEEP_CYC cycles; at the end, rem decrements; if the new rem = 0, go to IDLE, else go to GAP.
REQ-023 GAP: en_buz = 0 for exactly GAP_CYC cycles, then go to ON.
REQ-024 en_buz and busy shall be registered; en_buz = 1 only in ON; busy = 1 in ON and GAP.
REQ-025 en_buz shall rise on the cycle after the trigger cycle (latency 1).
REQ-026 All counters shall be sized to hold their parameter value and shall never wrap; the debounce and hold counters saturate.

Reset
REQ-027 While rst = 0: en_buz = 0, busy = 0, key_press = 0, key_long = 0, FSM = IDLE, rem = 0, all counters = 0, synchronizer and debounced level = 1 (released).
REQ-028 Reset asserted mid-pattern shall force en_buz low asynchronously; after release, no beep until a new trigger.
REQ-029 After reset release with key_n held low, the press shall be detected after the normal DEB_CYC window.

Verification (DEB_CYC=4, BEEP_CYC=8, GAP_CYC=6, LONG_CYC=40)
REQ-030 Bounce: key_n toggles every 2 cycles for 20 cycles, then stays low -> exactly one key_press pulse, DEB_CYC+2 cycles after the final settling, then one 8-cycle en_buz pulse.
REQ-031 Long hold: key_n low for 100 cycles -> key_press, then key_long 40 cycles later; beep restarts as 8 on / 6 off / 8 on; busy then falls.
REQ-032 req with req_cnt=3 -> en_buz pattern 8/6/8/6/8, busy high for 36 cycles; req with req_cnt=0 -> no activity.
REQ-033 Same-cycle req (cnt 3) and key_press -> single 8-cycle beep only.
REQ-034 req (cnt 2) during the first ON -> pattern restarts; en_buz stays continuously high for the cycles spent in ON before the restart plus 8, then a 6-cycle gap and an 8-cycle beep.
REQ-035 rst pulsed low during GAP -> en_buz, busy = 0 immediately; outputs stay idle after release.

Source files
------------

// File: rtl/key_beep_ctrl.sv
// Push-button front end (synchronizer, debounce, press/long-press pulses) feeding
// a restartable beep-pattern sequencer that drives the buzzer enable.
module key_beep_ctrl #(
    parameter int DEB_CYC  = 1_000_000,
    parameter int BEEP_CYC = 5_000_000,
    parameter int GAP_CYC  = 5_000_000,
    parameter int LONG_CYC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic       req,
    input  logic [1:0] req_cnt,
    output logic       en_buz,
    output logic       key_press,
    output logic       key_long,
    output logic       busy
);

    localparam int DW   = $clog2(DEB_CYC + 1);
    localparam int LW   = $clog2(LONG_CYC + 1);
    localparam int PMAX = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
    localparam int PW   = $clog2(PMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic [DW-1:0] deb_cnt_q;
    logic [LW-1:0] hold_cnt_q;
    logic          key_press_q;
    logic          key_long_q;

    state_t        state_q;
    logic [PW-1:0] cnt_q;
    logic [1:0]    rem_q;
    logic          en_buz_q;
    logic          busy_q;

    logic          trig_s;
    logic [1:0]    load_s;

    // Key front end: synchronizer, debounce window, press and long-hold pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            deb_q       <= 1'b1;
            deb_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            key_press_q <= 1'b0;
            key_long_q  <= 1'b0;
        end else begin
            sync1_q     <= key_n;
            sync2_q     <= sync1_q;
            key_press_q <= 1'b0;
            key_long_q  <= 1'b0;

            if (sync2_q != deb_q) begin
                if (deb_cnt_q == DW'(DEB_CYC - 1)) begin
                    deb_q       <= sync2_q;
                    deb_cnt_q   <= '0;
                    key_press_q <= ~sync2_q;
                end else begin
                    deb_cnt_q <= deb_cnt_q + DW'(1);
                end
            end else begin
                deb_cnt_q <= '0;
            end

            // Parking at LONG_CYC keeps key_long to a single pulse per press.
            if (deb_q) begin
                hold_cnt_q <= '0;
            end else if (hold_cnt_q == LW'(LONG_CYC - 1)) begin
                hold_cnt_q <= LW'(LONG_CYC);
                key_long_q <= 1'b1;
            end else if (hold_cnt_q != LW'(LONG_CYC)) begin
                hold_cnt_q <= hold_cnt_q + LW'(1);
            end else begin
                hold_cnt_q <= hold_cnt_q;
            end
        end
    end

    // Trigger arbitration: long press beats short press beats external request.
    always_comb begin
        trig_s = 1'b0;
        load_s = 2'd0;
        if (key_long_q) begin
            trig_s = 1'b1;
            load_s = 2'd2;
        end else if (key_press_q) begin
            trig_s = 1'b1;
            load_s = 2'd1;
        end else if (req && (req_cnt != 2'd0)) begin
            trig_s = 1'b1;
            load_s = req_cnt;
        end else begin
            trig_s = 1'b0;
            load_s = 2'd0;
        end
    end

    // Pattern sequencer; any trigger abandons the current pattern and restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= 2'd0;
            en_buz_q <= 1'b0;
            busy_q   <= 1'b0;
        end else if (trig_s) begin
            state_q  <= S_ON;
            cnt_q    <= '0;
            rem_q    <= load_s;
            en_buz_q <= 1'b1;
            busy_q   <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q    <= '0;
                    en_buz_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                S_ON: begin
                    if (cnt_q == PW'(BEEP_CYC - 1)) begin
                        cnt_q    <= '0;
                        rem_q    <= rem_q - 2'd1;
                        en_buz_q <= 1'b0;
                        if (rem_q == 2'd1) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_GAP;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q    <= cnt_q + PW'(1);
                        en_buz_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == PW'(GAP_CYC - 1)) begin
                        state_q  <= S_ON;
                        cnt_q    <= '0;
                        en_buz_q <= 1'b1;
                    end else begin
                        cnt_q    <= cnt_q + PW'(1);
                        en_buz_q <= 1'b0;
                    end
                    busy_q <= 1'b1;
                end
                default: begin
                    state_q  <= S_IDLE;
                    cnt_q    <= '0;
                    rem_q    <= 2'd0;
                    en_buz_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign en_buz    = en_buz_q;
    assign busy      = busy_q;
    assign key_press = key_press_q;
    assign key_long  = key_long_q;

endmodule

// File: tb/tb_key_beep_ctrl.sv
// Directed bench for key_beep_ctrl with short windows: DEB=4, BEEP=8, GAP=6, LONG=40.
module tb_key_beep_ctrl;

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       key_n   = 1'b1;
    logic       req     = 1'b0;
    logic [1:0] req_cnt = 2'd0;
    logic       en_buz;
    logic       key_press;
    logic       key_long;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    key_beep_ctrl #(
        .DEB_CYC (4),
        .BEEP_CYC(8),
        .GAP_CYC (6),
        .LONG_CYC(40)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_n    (key_n),
        .req      (req),
        .req_cnt  (req_cnt),
        .en_buz   (en_buz),
        .key_press(key_press),
        .key_long (key_long),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int s, input logic e_en,
                              input logic e_busy, input logic e_press, input logic e_long);
        chk($sformatf("%s.en_buz@%0d", tag, s), en_buz, e_en);
        chk($sformatf("%s.busy@%0d", tag, s), busy, e_busy);
        chk($sformatf("%s.key_press@%0d", tag, s), key_press, e_press);
        chk($sformatf("%s.key_long@%0d", tag, s), key_long, e_long);
    endtask

    // i = cycles since the trigger cycle (1 = first beep cycle); n-beep 8-on/6-off pattern
    function automatic logic exp_en(input int i, input int n);
        int p;
        int k;
        if (i < 1) return 1'b0;
        p = (i - 1) % 14;
        k = (i - 1) / 14;
        return (k < n) && (p < 8);
    endfunction

    function automatic logic exp_busy(input int i, input int n);
        int p;
        int k;
        if (i < 1) return 1'b0;
        p = (i - 1) % 14;
        k = (i - 1) / 14;
        return (k < n) && ((p < 8) || (k < n - 1));
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        step();
        step();
        check_outs("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) step();
        check_outs("post_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // bounce: toggle every 2 cycles for 20 cycles, then settle low
        for (int c = 0; c < 10; c++) begin
            key_n = (c % 2 == 0) ? 1'b0 : 1'b1;
            for (int r = 0; r < 2; r++) begin
                step();
                chk($sformatf("bounce.key_press@%0d", 2 * c + r), key_press, 1'b0);
            end
        end
        key_n = 1'b0;
        for (int s = 1; s <= 20; s++) begin
            step();
            check_outs("settle", s, exp_en(s - 6, 1), exp_busy(s - 6, 1), s == 6, 1'b0);
        end
        key_n = 1'b1;
        for (int s = 1; s <= 50; s++) begin
            step();
            check_outs("release", s, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // long hold: press pulse, long pulse 40 cycles later, 2-beep restart
        key_n = 1'b0;
        for (int s = 1; s <= 100; s++) begin
            step();
            check_outs("long", s, exp_en(s - 6, 1) | exp_en(s - 46, 2),
                       exp_busy(s - 6, 1) | exp_busy(s - 46, 2), s == 6, s == 46);
        end
        key_n = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            step();
            check_outs("long_rel", s, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // req with count 3: 8/6/8/6/8, busy for 36 cycles
        req     = 1'b1;
        req_cnt = 2'd3;
        for (int s = 1; s <= 40; s++) begin
            step();
            req     = 1'b0;
            req_cnt = 2'd0;
            check_outs("req3", s, exp_en(s, 3), exp_busy(s, 3), 1'b0, 1'b0);
        end

        // req with count 0 is ignored
        req     = 1'b1;
        req_cnt = 2'd0;
        for (int s = 1; s <= 12; s++) begin
            step();
            req = 1'b0;
            check_outs("req0", s, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // same-cycle key_press and req(3): key_press wins, single beep
        key_n = 1'b0;
        for (int s = 1; s <= 30; s++) begin
            step();
            check_outs("same", s, exp_en(s - 6, 1), exp_busy(s - 6, 1), s == 6, 1'b0);
            req     = (s == 6);
            req_cnt = (s == 6) ? 2'd3 : 2'd0;
        end
        key_n = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            step();
            check_outs("same_rel", s, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // restart: req(2) at the 4th ON cycle keeps en_buz high for 4+8 cycles
        req     = 1'b1;
        req_cnt = 2'd2;
        for (int s = 1; s <= 30; s++) begin
            step();
            check_outs("restart", s, (s <= 4) ? 1'b1 : exp_en(s - 4, 2),
                       (s <= 4) ? 1'b1 : exp_busy(s - 4, 2), 1'b0, 1'b0);
            req     = (s == 4);
            req_cnt = (s == 4) ? 2'd2 : 2'd0;
        end

        // reset asserted mid-ON drops en_buz without waiting for a clock edge
        req     = 1'b1;
        req_cnt = 2'd2;
        step();
        req     = 1'b0;
        req_cnt = 2'd0;
        step();
        step();
        chk("rst_on.pre_en", en_buz, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_on.en_async", en_buz, 1'b0);
        chk("rst_on.busy_async", busy, 1'b0);
        step();
        rst = 1'b1;
        for (int s = 1; s <= 25; s++) begin
            step();
            check_outs("rst_on.after", s, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // reset during GAP with key held low through release
        req     = 1'b1;
        req_cnt = 2'd2;
        for (int s = 1; s <= 10; s++) begin
            step();
            req     = 1'b0;
            req_cnt = 2'd0;
        end
        chk("rst_gap.pre_busy", busy, 1'b1);
        chk("rst_gap.pre_en", en_buz, 1'b0);
        #2;
        rst   = 1'b0;
        key_n = 1'b0;
        #1;
        chk("rst_gap.busy_async", busy, 1'b0);
        chk("rst_gap.en_async", en_buz, 1'b0);
        step();
        step();
        check_outs("rst_gap.held", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            step();
            check_outs("rst_gap.after", s, exp_en(s - 6, 1), exp_busy(s - 6, 1), s == 6, 1'b0);
        end
        key_n = 1'b1;
        for (int s = 1; s <= 20; s++) begin
            step();
            check_outs("rst_gap.rel", s, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
